ram_rw_checker: RTL and testbench
=================================

// Module: ram_rw_checker
// PURPOSE
//  Parametrised single-port RAM exerciser: on start, writes a selectable data pattern
//  to every address 0..DEPTH-1, reads all addresses back and compares against the
//  expected pattern, compensating for the RAM's read latency. Reports done, pass/fail,
//  error count and first failing address. It drives the RAM port of the 1-port RAM IP
//  in place of a fixed 8x32 write/read sequencer.
// PARAMETERS
//  DATA_W  8   RAM data width, bits (>=2)
//  ADDR_W  5   RAM address width, bits
//  DEPTH   32  words exercised, 2..2**ADDR_W; address wraps at DEPTH-1
//  RD_LAT  1   cycles from read address presented to ram_rd_data valid (1..4)
// PORTS
//  clk             in   1          single clock, rising edge
//  rst_n           in   1          synchronous, active-low reset
//  start           in   1          begin a test run; sampled only in IDLE
//  mode            in   2          pattern select; latched when start accepted
//  ram_rd_data     in   DATA_W     RAM read data
//  ram_en          out  1          RAM enable
//  ram_we          out  1          RAM write enable, 1 = write, 0 = read
//  ram_addr        out  ADDR_W     RAM address
//  ram_wr_data     out  DATA_W     RAM write data
//  busy            out  1          high from start acceptance until done pulse
//  done            out  1          one-cycle pulse at end of run
//  pass            out  1          1 = last run had zero mismatches; held until next start
//  err_cnt         out  ADDR_W+1   mismatches in last run, saturating at all-ones
//  first_err_addr  out  ADDR_W     address of first mismatch in last run (0 if none)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): all outputs 0, FSM to IDLE, latency pipe flushed.
//    Reset mid-run aborts immediately; no done pulse, pending compares discarded.
//  - States: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
//  - IDLE: ram_en=ram_we=0. start=1 -> latch mode, clear err_cnt/first_err_addr/pass,
//    busy=1, go WRITE. start in any other state is ignored.
//  - WRITE: one word per cycle; ram_en=1, ram_we=1, ram_addr=0..DEPTH-1,
//    ram_wr_data=P(addr). After addr DEPTH-1 -> READ, ram_addr restarts at 0.
//  - READ: ram_en=1, ram_we=0, ram_addr=0..DEPTH-1, one per cycle. After DEPTH-1 -> DRAIN.
//  - DRAIN: ram_en=0 for exactly RD_LAT cycles while last reads return -> DONE.
//  - DONE: one cycle; done=1, busy=0, pass=(err_cnt==0) -> IDLE.
//  - Compare: address and valid flag of each read are delayed RD_LAT cycles in a shift
//    pipe; when the delayed valid is 1, ram_rd_data is compared to P(delayed addr).
//    Exactly DEPTH compares per run. On mismatch: err_cnt+1 (saturating); if it is the
//    first mismatch, capture delayed addr in first_err_addr.
//  - Pattern P(a), a zero-extended/truncated to DATA_W:
//    mode 0 incrementing: a mod 2**DATA_W
//    mode 1 inverted: ~a
//    mode 2 checkerboard: even a -> 0101..01 (0x55 for 8b), odd a -> 1010..10 (0xAA)
//    mode 3 walking one: 1 << (a mod DATA_W)
//  - Run length: DEPTH write + DEPTH read + RD_LAT drain + 1 done cycle = 2*DEPTH+RD_LAT+1
//    cycles after start acceptance.
//  - start held high through DONE: new run is accepted on the first IDLE cycle after DONE.
// TESTING
//  1 Defaults, ideal RAM model RD_LAT=1, mode 0, start pulse -> writes 0..31 at addr
//    0..31, done at cycle 66 after acceptance, pass=1, err_cnt=0.
//  2 Model corrupts addr 5 read (bit 0 flipped), mode 1 -> pass=0, err_cnt=1,
//    first_err_addr=5; corrupt addr 5 and 9 -> err_cnt=2, first_err_addr=5.
//  3 RD_LAT=3, DEPTH=20, ADDR_W=5, mode 2 -> addr 19 last written/read, 0x55/0xAA
//    alternate, exactly 20 compares, done at cycle 44, pass=1.
//  4 DATA_W=4, mode 3, DEPTH=32 -> wr_data cycles 1,2,4,8 repeating; mode 0 wraps 15->0.
//  5 Model returns all-zeros, DEPTH=32 -> err_cnt saturates at 63 only when ADDR_W+1
//    bits overflow (use DEPTH=32, ADDR_W=5: err_cnt=32); start pulses mid-run ignored.
//  6 rst_n low during READ -> next cycle all outputs 0, no done; fresh start -> clean pass.

Source files
------------

// File: rtl/ram_rw_checker.sv
// ram_rw_checker
//   Single-port RAM exerciser. On start it writes a selectable pattern to every
//   address 0..DEPTH-1. It then reads every address back and compares each word
//   against the expected pattern. Read data is sampled RD_LAT cycles after its
//   address was presented.
//
//   Ports
//     clk, rst_n        clock, synchronous active-low reset
//     start, mode       run request (sampled in IDLE) and pattern select
//     ram_rd_data       RAM read data
//     ram_en, ram_we    RAM enable / write enable
//     ram_addr          RAM address
//     ram_wr_data       RAM write data
//     busy, done        run in progress / one-cycle end-of-run pulse
//     pass              last run had no mismatches (held until next start)
//     err_cnt           mismatch count of last run, saturating
//     first_err_addr    address of first mismatch of last run (0 if none)
//
//   state | meaning
//   IDLE  | waiting for start, RAM disabled
//   WRITE | writing P(addr) to addr 0..DEPTH-1
//   READ  | issuing reads for addr 0..DEPTH-1
//   DRAIN | RD_LAT cycles letting the last reads return
//   DONE  | one cycle, done pulse and pass verdict

module ram_rw_checker #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [2:0]        DRAIN_TC  = 3'(RD_LAT - 1);

    state_t              state_q;
    logic [1:0]          mode_q;
    logic                ram_en_q, ram_we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_wr_data_q;
    logic                busy_q, done_q, pass_q;
    logic [ADDR_W:0]     err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;
    logic [2:0]          drain_q;

    // Read-return tracking: valid flag and address of each issued read, delayed
    // so that the tail lines up with the cycle its data is on ram_rd_data.
    logic [RD_LAT-1:0]   vld_pipe_q;
    logic [ADDR_W-1:0]   addr_pipe_q [RD_LAT];

    function automatic logic [DATA_W-1:0] pat_f(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] az;
        logic [DATA_W-1:0] cb;
        az = DATA_W'(a);
        // Checkerboard: bit 0 set on even addresses, bit 1 set on odd ones.
        for (int i = 0; i < DATA_W; i++) begin
            cb[i] = ((i % 2) == 0) ? ~a[0] : a[0];
        end
        case (m)
            2'd0:    pat_f = az;
            2'd1:    pat_f = ~az;
            2'd2:    pat_f = cb;
            default: pat_f = DATA_W'(1) << (int'(a) % DATA_W);
        endcase
    endfunction

    always_comb begin
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        if (vld_pipe_q[RD_LAT-1] &&
            (ram_rd_data != pat_f(mode_q, addr_pipe_q[RD_LAT-1]))) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
            if (err_cnt_q == '0) begin
                first_err_d = addr_pipe_q[RD_LAT-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mode_q        <= '0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_cnt_q     <= '0;
            first_err_q   <= '0;
            drain_q       <= '0;
            vld_pipe_q    <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_pipe_q[i] <= '0;
            end
        end else begin
            vld_pipe_q[0]  <= ram_en_q & ~ram_we_q;
            addr_pipe_q[0] <= ram_addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                addr_pipe_q[i] <= addr_pipe_q[i-1];
            end

            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            done_q      <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q        <= mode;
                        err_cnt_q     <= '0;
                        first_err_q   <= '0;
                        pass_q        <= 1'b0;
                        busy_q        <= 1'b1;
                        ram_en_q      <= 1'b1;
                        ram_we_q      <= 1'b1;
                        ram_addr_q    <= '0;
                        ram_wr_data_q <= pat_f(mode, '0);
                        state_q       <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (ram_addr_q == LAST_ADDR) begin
                        ram_we_q      <= 1'b0;
                        ram_addr_q    <= '0;
                        ram_wr_data_q <= '0;
                        state_q       <= S_READ;
                    end else begin
                        ram_addr_q    <= ram_addr_q + ADDR_ONE;
                        ram_wr_data_q <= pat_f(mode_q, ram_addr_q + ADDR_ONE);
                    end
                end
                S_READ: begin
                    if (ram_addr_q == LAST_ADDR) begin
                        ram_en_q   <= 1'b0;
                        ram_addr_q <= '0;
                        drain_q    <= DRAIN_TC;
                        state_q    <= S_DRAIN;
                    end else begin
                        ram_addr_q <= ram_addr_q + ADDR_ONE;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) begin
                        // The final compare lands this cycle, so judge on err_cnt_d.
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (err_cnt_d == '0);
                        state_q <= S_DONE;
                    end else begin
                        drain_q <= drain_q - 3'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_en         = ram_en_q;
    assign ram_we         = ram_we_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wr_data    = ram_wr_data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_ram_rw_checker.sv
module tb_ram_rw_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: RD_LAT=3, DEPTH=20. Instance 2: DATA_W=4.
    logic [2:0] start_s;
    logic [1:0] mode_s [3];
    logic [2:0] en_w, we_w, busy_w, done_w, pass_w;
    logic [4:0] addr_w [3];
    logic [7:0] wd_w   [3];
    logic [7:0] rd_w   [3];
    logic [5:0] err_w  [3];
    logic [4:0] fea_w  [3];
    logic [7:0] wd0, wd1;
    logic [3:0] wd4, rd4;

    assign wd_w[0] = wd0;
    assign wd_w[1] = wd1;
    assign wd_w[2] = {4'h0, wd4};
    assign rd4     = rd_w[2][3:0];

    ram_rw_checker u_def (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .mode(mode_s[0]), .ram_rd_data(rd_w[0]),
        .ram_en(en_w[0]), .ram_we(we_w[0]), .ram_addr(addr_w[0]), .ram_wr_data(wd0),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err_w[0]),
        .first_err_addr(fea_w[0]));

    ram_rw_checker #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .mode(mode_s[1]), .ram_rd_data(rd_w[1]),
        .ram_en(en_w[1]), .ram_we(we_w[1]), .ram_addr(addr_w[1]), .ram_wr_data(wd1),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err_w[1]),
        .first_err_addr(fea_w[1]));

    ram_rw_checker #(.DATA_W(4), .ADDR_W(5), .DEPTH(32), .RD_LAT(1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .mode(mode_s[2]), .ram_rd_data(rd4),
        .ram_en(en_w[2]), .ram_we(we_w[2]), .ram_addr(addr_w[2]), .ram_wr_data(wd4),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_cnt(err_w[2]),
        .first_err_addr(fea_w[2]));

    function automatic int dep(input int k); return (k == 1) ? 20 : 32; endfunction
    function automatic int rl(input int k);  return (k == 1) ? 3 : 1;   endfunction
    function automatic int dw(input int k);  return (k == 2) ? 4 : 8;   endfunction

    // RAM models with per-address bit-0 corruption or all-zero read data.
    logic [7:0]  mem [3][32];
    logic [7:0]  rp  [3][4];
    logic [31:0] corrupt [3];
    logic [2:0]  zero_rd;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (en_w[k] && we_w[k]) mem[k][addr_w[k]] <= wd_w[k];
            if (en_w[k] && !we_w[k])
                rp[k][0] <= zero_rd[k] ? 8'h00 : (mem[k][addr_w[k]] ^ {7'b0, corrupt[k][addr_w[k]]});
            else
                rp[k][0] <= 8'h3C;
            for (int j = 1; j < 4; j++) rp[k][j] <= rp[k][j-1];
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) rd_w[k] = rp[k][rl(k)-1];
    end

    int total = 0;
    int bad   = 0;
    int wr_seen [32];

    // Reference pattern from plain integer arithmetic.
    function automatic int ref_pat(input int m, input int a, input int w);
        int mask, v;
        mask = (1 << w) - 1;
        v = 0;
        case (m)
            0: v = a & mask;
            1: v = (~a) & mask;
            2: for (int i = 0; i < w; i++) if ((i % 2) == (a % 2)) v = v | (1 << i);
            default: v = 1 << (a % w);
        endcase
        return v;
    endfunction

    // Expected verdict of a run given the RAM model's faults.
    function automatic void model(input int k, input int m, output int ec, output int ef);
        int e, g;
        ec = 0;
        ef = 0;
        for (int a = 0; a < dep(k); a++) begin
            e = ref_pat(m, a, dw(k));
            g = zero_rd[k] ? 0 : (e ^ int'(corrupt[k][a]));
            if (g != e) begin
                if (ec == 0) ef = a;
                ec++;
            end
        end
        if (ec > 63) ec = 63;
    endfunction

    // Starts a run on instance k and follows it cycle by cycle until done or a budget.
    task automatic run(input int k, input int m, input bit hold, input bit poke,
                       output int done_n, output int seq_err, output int first_bad);
        int d, l, w;
        bit ok, e_en, e_we, e_busy, e_done;
        d = dep(k); l = rl(k); w = dw(k);
        mode_s[k]  = 2'(m);
        start_s[k] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_s[k] = 1'b0;
        done_n = -1; seq_err = 0; first_bad = -1;
        for (int n = 1; n <= 2*d + l + 10; n++) begin
            @(negedge clk);
            e_en   = (n <= 2*d);
            e_we   = (n <= d);
            e_busy = (n <= 2*d + l);
            e_done = (n == 2*d + l + 1);
            ok = (en_w[k] == e_en) && (we_w[k] == e_we) && (busy_w[k] == e_busy) && (done_w[k] == e_done);
            if (e_en) ok = ok && (int'(addr_w[k]) == ((n <= d) ? n - 1 : n - 1 - d));
            if (e_we) begin
                ok = ok && (int'(wd_w[k]) == ref_pat(m, n - 1, w));
                wr_seen[n-1] = int'(wd_w[k]);
            end
            if (!ok) begin
                seq_err++;
                if (first_bad < 0) first_bad = n;
            end
            if (done_w[k] === 1'b1) begin
                done_n = n;
                break;
            end
            if (poke) start_s[k] = (n >= 5 && n <= 2*d && (n % 7) == 0);
        end
    endtask

    task automatic test_reset();
        total++; if (en_w !== 3'b0 || we_w !== 3'b0) begin bad++; $display("FAIL reset_en_we got en=%b we=%b want 0", en_w, we_w); end
        total++; if (busy_w !== 3'b0 || done_w !== 3'b0) begin bad++; $display("FAIL reset_busy_done got busy=%b done=%b want 0", busy_w, done_w); end
        total++; if (pass_w !== 3'b0) begin bad++; $display("FAIL reset_pass got %b want 0", pass_w); end
        total++; if (addr_w[0] !== 5'd0 || wd_w[0] !== 8'd0) begin bad++; $display("FAIL reset_addr_data got addr=%0d wd=%0h want 0", addr_w[0], wd_w[0]); end
        total++; if (err_w[0] !== 6'd0 || fea_w[0] !== 5'd0) begin bad++; $display("FAIL reset_err got cnt=%0d first=%0d want 0", err_w[0], fea_w[0]); end
    endtask

    task automatic test_basic();
        int dn, se, fb;
        corrupt[0] = 0; zero_rd[0] = 0;
        run(0, 0, 0, 0, dn, se, fb);
        total++; if (dn != 66) begin bad++; $display("FAIL basic_done_cycle got %0d want 66", dn); end
        total++; if (se != 0) begin bad++; $display("FAIL basic_sequence got %0d bad cycles (first %0d) want 0", se, fb); end
        total++; if (pass_w[0] !== 1'b1 || err_w[0] !== 6'd0) begin bad++; $display("FAIL basic_verdict got pass=%b err=%0d want 1/0", pass_w[0], err_w[0]); end
        total++; if (wr_seen[31] != 31) begin bad++; $display("FAIL basic_last_write got %0d want 31", wr_seen[31]); end
        @(negedge clk);
        total++; if (done_w[0] !== 1'b0 || pass_w[0] !== 1'b1) begin bad++; $display("FAIL basic_after_done got done=%b pass=%b want 0/1", done_w[0], pass_w[0]); end
    endtask

    task automatic test_corrupt();
        int dn, se, fb;
        corrupt[0] = 32'h0000_0020;
        run(0, 1, 0, 0, dn, se, fb);
        total++; if (pass_w[0] !== 1'b0 || err_w[0] !== 6'd1 || fea_w[0] !== 5'd5) begin bad++; $display("FAIL corrupt_one got pass=%b err=%0d first=%0d want 0/1/5", pass_w[0], err_w[0], fea_w[0]); end
        @(negedge clk);
        corrupt[0] = 32'h0000_0220;
        run(0, 1, 0, 0, dn, se, fb);
        total++; if (pass_w[0] !== 1'b0 || err_w[0] !== 6'd2 || fea_w[0] !== 5'd5) begin bad++; $display("FAIL corrupt_two got pass=%b err=%0d first=%0d want 0/2/5", pass_w[0], err_w[0], fea_w[0]); end
        total++; if (se != 0 || dn != 66) begin bad++; $display("FAIL corrupt_sequence got err_cycles=%0d done=%0d want 0/66", se, dn); end
        corrupt[0] = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int dn, se, fb, m, ec, ef;
        for (int it = 0; it < 5; it++) begin
            m = $urandom_range(0, 3);
            corrupt[0] = $urandom & $urandom & $urandom;
            model(0, m, ec, ef);
            run(0, m, 0, 0, dn, se, fb);
            total++;
            if (se != 0 || dn != 66 || int'(err_w[0]) != ec || int'(fea_w[0]) != ef || pass_w[0] !== (ec == 0)) begin
                bad++;
                $display("FAIL random_run%0d mode=%0d got seq=%0d done=%0d err=%0d first=%0d pass=%b want 0/66/%0d/%0d/%0d",
                         it, m, se, dn, err_w[0], fea_w[0], pass_w[0], ec, ef, ec == 0);
            end
            @(negedge clk);
        end
        corrupt[0] = 0;
    endtask

    task automatic test_all_zero();
        int dn, se, fb, ec, ef;
        zero_rd[0] = 1'b1;
        model(0, 2, ec, ef);
        run(0, 2, 0, 1, dn, se, fb);
        total++; if (int'(err_w[0]) != ec || err_w[0] !== 6'd32 || fea_w[0] !== 5'd0) begin bad++; $display("FAIL zero_err got err=%0d first=%0d want %0d/0", err_w[0], fea_w[0], ec); end
        total++; if (dn != 66 || se != 0) begin bad++; $display("FAIL zero_start_ignored got done=%0d seq=%0d want 66/0", dn, se); end
        zero_rd[0] = 1'b0;
        @(negedge clk);
        total++; if (busy_w[0] !== 1'b0 || en_w[0] !== 1'b0) begin bad++; $display("FAIL zero_idle got busy=%b en=%b want 0/0", busy_w[0], en_w[0]); end
    endtask

    task automatic test_back_to_back();
        int dn, se, fb, cnt;
        run(0, 3, 1, 0, dn, se, fb);
        total++; if (dn != 66 || se != 0) begin bad++; $display("FAIL b2b_first got done=%0d seq=%0d want 66/0", dn, se); end
        @(negedge clk);
        total++; if (busy_w[0] !== 1'b0 || en_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b en=%b done=%b want 0", busy_w[0], en_w[0], done_w[0]); end
        @(negedge clk);
        total++; if (busy_w[0] !== 1'b1 || en_w[0] !== 1'b1 || we_w[0] !== 1'b1 || addr_w[0] !== 5'd0) begin bad++; $display("FAIL b2b_restart got busy=%b en=%b we=%b addr=%0d want 1/1/1/0", busy_w[0], en_w[0], we_w[0], addr_w[0]); end
        start_s[0] = 1'b0;
        cnt = 0;
        while (done_w[0] !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        total++; if (cnt != 65 || pass_w[0] !== 1'b1) begin bad++; $display("FAIL b2b_second got cycles=%0d pass=%b want 65/1", cnt, pass_w[0]); end
        @(negedge clk);
    endtask

    task automatic test_lat3();
        int dn, se, fb, ec, ef;
        corrupt[1] = 0;
        run(1, 2, 0, 0, dn, se, fb);
        total++; if (dn != 44 || se != 0) begin bad++; $display("FAIL lat3_timing got done=%0d seq=%0d want 44/0", dn, se); end
        total++; if (wr_seen[0] != 8'h55 || wr_seen[1] != 8'hAA || wr_seen[19] != 8'hAA) begin bad++; $display("FAIL lat3_checker got %0h %0h %0h want 55 aa aa", wr_seen[0], wr_seen[1], wr_seen[19]); end
        total++; if (pass_w[1] !== 1'b1 || err_w[1] !== 6'd0) begin bad++; $display("FAIL lat3_pass got pass=%b err=%0d want 1/0", pass_w[1], err_w[1]); end
        @(negedge clk);
        corrupt[1] = 32'h0008_0001;
        model(1, 0, ec, ef);
        run(1, 0, 0, 0, dn, se, fb);
        total++; if (int'(err_w[1]) != ec || int'(fea_w[1]) != ef || pass_w[1] !== 1'b0) begin bad++; $display("FAIL lat3_edges got err=%0d first=%0d pass=%b want %0d/%0d/0", err_w[1], fea_w[1], pass_w[1], ec, ef); end
        corrupt[1] = 0;
        @(negedge clk);
    endtask

    task automatic test_narrow();
        int dn, se, fb;
        corrupt[2] = 0;
        run(2, 3, 0, 0, dn, se, fb);
        total++; if (wr_seen[0] != 1 || wr_seen[1] != 2 || wr_seen[2] != 4 || wr_seen[3] != 8 || wr_seen[4] != 1) begin bad++; $display("FAIL narrow_walk got %0d %0d %0d %0d %0d want 1 2 4 8 1", wr_seen[0], wr_seen[1], wr_seen[2], wr_seen[3], wr_seen[4]); end
        total++; if (dn != 66 || se != 0 || pass_w[2] !== 1'b1) begin bad++; $display("FAIL narrow_walk_run got done=%0d seq=%0d pass=%b want 66/0/1", dn, se, pass_w[2]); end
        @(negedge clk);
        run(2, 0, 0, 0, dn, se, fb);
        total++; if (wr_seen[15] != 15 || wr_seen[16] != 0 || wr_seen[17] != 1) begin bad++; $display("FAIL narrow_wrap got %0d %0d %0d want 15 0 1", wr_seen[15], wr_seen[16], wr_seen[17]); end
        total++; if (se != 0 || pass_w[2] !== 1'b1) begin bad++; $display("FAIL narrow_inc_run got seq=%0d pass=%b want 0/1", se, pass_w[2]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dn, se, fb, dcount;
        corrupt[0] = 32'h0000_0004;
        mode_s[0]  = 2'd0;
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        for (int n = 1; n <= 40; n++) @(negedge clk);
        total++; if (busy_w[0] !== 1'b1 || err_w[0] !== 6'd1) begin bad++; $display("FAIL midreset_pre got busy=%b err=%0d want 1/1", busy_w[0], err_w[0]); end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({en_w[0], we_w[0], addr_w[0], wd_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], fea_w[0]} !== '0) begin
            bad++;
            $display("FAIL midreset_clear got en=%b we=%b addr=%0d wd=%0h busy=%b done=%b pass=%b err=%0d first=%0d want all 0",
                     en_w[0], we_w[0], addr_w[0], wd_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], fea_w[0]);
        end
        rst_n = 1'b1;
        corrupt[0] = 0;
        dcount = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) dcount++;
        end
        total++; if (dcount != 0) begin bad++; $display("FAIL midreset_no_done got %0d active cycles want 0", dcount); end
        run(0, $urandom_range(0, 3), 0, 0, dn, se, fb);
        total++; if (dn != 66 || se != 0 || pass_w[0] !== 1'b1 || err_w[0] !== 6'd0) begin bad++; $display("FAIL midreset_fresh got done=%0d seq=%0d pass=%b err=%0d want 66/0/1/0", dn, se, pass_w[0], err_w[0]); end
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_s = 3'b0;
        for (int k = 0; k < 3; k++) begin
            mode_s[k]  = 2'd0;
            corrupt[k] = 0;
        end
        zero_rd = 3'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_corrupt();
        test_random();
        test_all_zero();
        test_back_to_back();
        test_lat3();
        test_narrow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
